// File: rtl/screen_sequencer.sv
// Screen-state sequencer: turns the timer flag levels into a screen code, runs the round clock,
// times the snitch power-up, applies time-turner bonuses and latches final scores and the winner.
module screen_sequencer #(
    parameter int unsigned SEC_CYCLES      = 50000000,
    parameter int unsigned GAME_SECS       = 60,
    parameter int unsigned POWERUP_SECS    = 3,
    parameter int unsigned TT_BONUS_SECS   = 5,
    parameter int unsigned SCORE_HOLD_SECS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       logo,
    input  logic       select_mode_screen,
    input  logic       selected_a_mode,
    input  logic       two_player_mode,
    input  logic       end_of_game,
    input  logic       end_game_early,
    input  logic       play_again,
    input  logic       snitch_powerup,
    input  logic       time_turner_on,
    input  logic [7:0] score_p1,
    input  logic [7:0] score_p2,
    output logic [2:0] screen_id,
    output logic [7:0] secs_left,
    output logic       snitch_active,
    output logic       restart,
    output logic [7:0] final_p1,
    output logic [7:0] final_p2,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        S_LOGO   = 3'd0,
        S_MODE   = 3'd1,
        S_PLAY1  = 3'd2,
        S_PLAY2  = 3'd3,
        S_SCORE  = 3'd4,
        S_REPLAY = 3'd5
    } state_t;

    localparam int unsigned CW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(SEC_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [8:0]    GAME9     = 9'(GAME_SECS);
    localparam logic [8:0]    BONUS9    = 9'(TT_BONUS_SECS);
    localparam logic [7:0]    POWER8    = 8'(POWERUP_SECS);
    localparam logic [7:0]    HOLD8     = 8'(SCORE_HOLD_SECS);

    state_t        state_reg, state_next;
    logic [CW-1:0] tick_cnt_reg, tick_cnt_next;
    logic [7:0]    secs_left_reg, secs_left_next;
    logic [7:0]    snitch_cnt_reg, snitch_cnt_next;
    logic          snitch_active_reg, snitch_active_next;
    logic [7:0]    hold_cnt_reg, hold_cnt_next;
    logic          snitch_q_reg, tt_q_reg;
    logic          restart_reg, restart_next;
    logic [7:0]    final_p1_reg, final_p1_next;
    logic [7:0]    final_p2_reg, final_p2_next;
    logic [1:0]    winner_reg, winner_next;

    logic       in_play, in_run, tick, snitch_evt, tt_evt;
    logic       flag_end, round_end, hold_reached;
    logic [8:0] secs_dec, secs_bonus, secs_tt, secs_after;

    always_comb begin
        in_play    = (state_reg == S_PLAY1) || (state_reg == S_PLAY2);
        in_run     = in_play || (state_reg == S_SCORE);
        tick       = in_run && (tick_cnt_reg == TICK_LAST);
        snitch_evt = in_play && snitch_powerup && !snitch_q_reg;
        tt_evt     = in_play && time_turner_on && !tt_q_reg;

        // Decrement saturates at zero before the bonus is added, then clamp to the round length.
        secs_dec   = (tick && (secs_left_reg != 8'd0)) ? {1'b0, secs_left_reg} - 9'd1
                                                       : {1'b0, secs_left_reg};
        secs_bonus = tt_evt ? secs_dec + BONUS9 : secs_dec;
        secs_tt    = (secs_bonus > GAME9) ? GAME9 : secs_bonus;

        // A quit or game-over flag beats a simultaneous time-turner bonus.
        flag_end   = end_of_game || end_game_early;
        secs_after = flag_end ? secs_dec : secs_tt;
        round_end  = flag_end || (secs_after == 9'd0);

        // Hold is measured from SCORE entry, so the tick that completes it may release the screen.
        hold_reached = (hold_cnt_reg >= HOLD8) || (tick && (hold_cnt_reg == HOLD8 - 8'd1));
    end

    always_comb begin
        state_next         = state_reg;
        tick_cnt_next      = in_run ? (tick ? '0 : tick_cnt_reg + CNT_ONE) : tick_cnt_reg;
        secs_left_next     = secs_left_reg;
        snitch_cnt_next    = snitch_cnt_reg;
        snitch_active_next = snitch_active_reg;
        hold_cnt_next      = hold_cnt_reg;
        restart_next       = 1'b0;
        final_p1_next      = final_p1_reg;
        final_p2_next      = final_p2_reg;
        winner_next        = winner_reg;

        if (snitch_evt) begin
            snitch_cnt_next    = POWER8;
            snitch_active_next = 1'b1;
        end else if (tick && snitch_active_reg) begin
            if (snitch_cnt_reg <= 8'd1) begin
                snitch_cnt_next    = 8'd0;
                snitch_active_next = 1'b0;
            end else begin
                snitch_cnt_next = snitch_cnt_reg - 8'd1;
            end
        end

        if ((state_reg == S_SCORE) && tick && (hold_cnt_reg != 8'hFF))
            hold_cnt_next = hold_cnt_reg + 8'd1;

        case (state_reg)
            S_LOGO: begin
                if (!logo && select_mode_screen)
                    state_next = S_MODE;
            end
            S_MODE: begin
                if (two_player_mode || selected_a_mode) begin
                    state_next         = two_player_mode ? S_PLAY2 : S_PLAY1;
                    secs_left_next     = GAME9[7:0];
                    tick_cnt_next      = '0;
                    snitch_cnt_next    = 8'd0;
                    snitch_active_next = 1'b0;
                end
            end
            S_PLAY1, S_PLAY2: begin
                secs_left_next = secs_after[7:0];
                if (round_end) begin
                    state_next         = S_SCORE;
                    final_p1_next      = score_p1;
                    final_p2_next      = score_p2;
                    snitch_cnt_next    = 8'd0;
                    snitch_active_next = 1'b0;
                    tick_cnt_next      = '0;
                    hold_cnt_next      = 8'd0;
                    if (state_reg == S_PLAY1)
                        winner_next = 2'b01;
                    else if (score_p1 > score_p2)
                        winner_next = 2'b01;
                    else if (score_p2 > score_p1)
                        winner_next = 2'b10;
                    else
                        winner_next = 2'b00;
                end
            end
            S_SCORE: begin
                if (hold_reached && play_again) begin
                    state_next   = S_REPLAY;
                    restart_next = 1'b1;
                end
            end
            S_REPLAY: begin
                state_next = S_MODE;
            end
            default: begin
                state_next = S_LOGO;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= S_LOGO;
            tick_cnt_reg      <= '0;
            secs_left_reg     <= 8'd0;
            snitch_cnt_reg    <= 8'd0;
            snitch_active_reg <= 1'b0;
            hold_cnt_reg      <= 8'd0;
            snitch_q_reg      <= 1'b0;
            tt_q_reg          <= 1'b0;
            restart_reg       <= 1'b0;
            final_p1_reg      <= 8'd0;
            final_p2_reg      <= 8'd0;
            winner_reg        <= 2'b00;
        end else begin
            state_reg         <= state_next;
            tick_cnt_reg      <= tick_cnt_next;
            secs_left_reg     <= secs_left_next;
            snitch_cnt_reg    <= snitch_cnt_next;
            snitch_active_reg <= snitch_active_next;
            hold_cnt_reg      <= hold_cnt_next;
            snitch_q_reg      <= snitch_powerup;
            tt_q_reg          <= time_turner_on;
            restart_reg       <= restart_next;
            final_p1_reg      <= final_p1_next;
            final_p2_reg      <= final_p2_next;
            winner_reg        <= winner_next;
        end
    end

    assign screen_id     = state_reg;
    assign secs_left     = secs_left_reg;
    assign snitch_active = snitch_active_reg;
    assign restart       = restart_reg;
    assign final_p1      = final_p1_reg;
    assign final_p2      = final_p2_reg;
    assign winner        = winner_reg;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with short timing parameters; expected values are hand-computed.
module tb_screen_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       logo, select_mode_screen, selected_a_mode, two_player_mode;
    logic       end_of_game, end_game_early, play_again, snitch_powerup, time_turner_on;
    logic [7:0] score_p1, score_p2;
    logic [2:0] screen_id;
    logic [7:0] secs_left;
    logic       snitch_active, restart;
    logic [7:0] final_p1, final_p2;
    logic [1:0] winner;

    int checks   = 0;
    int failures = 0;
    int e        = 0;
    int restart_cnt = 0;

    screen_sequencer #(
        .SEC_CYCLES(10), .GAME_SECS(5), .POWERUP_SECS(2), .TT_BONUS_SECS(3), .SCORE_HOLD_SECS(2)
    ) dut (
        .clock(clock), .reset(reset), .logo(logo), .select_mode_screen(select_mode_screen),
        .selected_a_mode(selected_a_mode), .two_player_mode(two_player_mode),
        .end_of_game(end_of_game), .end_game_early(end_game_early), .play_again(play_again),
        .snitch_powerup(snitch_powerup), .time_turner_on(time_turner_on),
        .score_p1(score_p1), .score_p2(score_p2), .screen_id(screen_id), .secs_left(secs_left),
        .snitch_active(snitch_active), .restart(restart), .final_p1(final_p1),
        .final_p2(final_p2), .winner(winner)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (restart) restart_cnt++;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            e++;
        end
    endtask

    task automatic run_to(input int t);
        cyc(t - e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; logo = 1'b1; select_mode_screen = 1'b0; selected_a_mode = 1'b0;
        two_player_mode = 1'b0; end_of_game = 1'b0; end_game_early = 1'b0; play_again = 1'b0;
        snitch_powerup = 1'b0; time_turner_on = 1'b0; score_p1 = 8'd0; score_p2 = 8'd0;
        cyc(2);
        check_val("rst_screen", screen_id, 0);
        check_val("rst_secs", secs_left, 0);
        check_val("rst_snitch", snitch_active, 0);
        check_val("rst_restart", restart, 0);
        check_val("rst_final_p1", final_p1, 0);
        check_val("rst_winner", winner, 0);
        reset = 1'b0;
        cyc(2);
        check_val("logo_hold", screen_id, 0);

        // Test 1: one-player round runs out the clock
        logo = 1'b0; select_mode_screen = 1'b1; selected_a_mode = 1'b1;
        score_p1 = 8'd3; score_p2 = 8'd8;
        cyc(1);
        check_val("t1_mode", screen_id, 1);
        cyc(1);
        check_val("t1_play1", screen_id, 2);
        check_val("t1_secs_init", secs_left, 5);
        e = 0;
        selected_a_mode = 1'b0;
        run_to(9);
        check_val("t1_secs_before_tick", secs_left, 5);
        run_to(10);
        check_val("t1_secs_tick1", secs_left, 4);
        run_to(49);
        check_val("t1_secs_49", secs_left, 1);
        check_val("t1_still_play", screen_id, 2);
        run_to(50);
        check_val("t1_score", screen_id, 4);
        check_val("t1_secs_zero", secs_left, 0);
        check_val("t1_winner_p1", winner, 1);
        check_val("t1_final_p1", final_p1, 3);
        check_val("t1_final_p2", final_p2, 8);

        // Test 3: early play_again is held off until the scoreboard hold expires
        play_again = 1'b1;
        cyc(19);
        check_val("t3_score_hold", screen_id, 4);
        check_val("t3_no_restart", restart, 0);
        cyc(1);
        check_val("t3_replay", screen_id, 5);
        check_val("t3_restart", restart, 1);
        play_again = 1'b0;
        cyc(1);
        check_val("t3_mode", screen_id, 1);
        check_val("t3_restart_clr", restart, 0);

        // Test 2: two-player round, both end flags at once, then a tie
        two_player_mode = 1'b1; selected_a_mode = 1'b1;
        cyc(1);
        check_val("t2_play2", screen_id, 3);
        check_val("t2_secs", secs_left, 5);
        two_player_mode = 1'b0; selected_a_mode = 1'b0;
        score_p1 = 8'd7; score_p2 = 8'd9;
        cyc(3);
        end_of_game = 1'b1; end_game_early = 1'b1;
        cyc(1);
        check_val("t2_score", screen_id, 4);
        check_val("t2_final_p1", final_p1, 7);
        check_val("t2_final_p2", final_p2, 9);
        check_val("t2_winner_p2", winner, 2);
        end_of_game = 1'b0; end_game_early = 1'b0;
        play_again = 1'b1;
        cyc(19);
        check_val("t2_hold", screen_id, 4);
        cyc(1);
        check_val("t2_replay", screen_id, 5);
        play_again = 1'b0;
        cyc(1);
        check_val("t2_mode", screen_id, 1);

        two_player_mode = 1'b1;
        cyc(1);
        check_val("t2b_play2", screen_id, 3);
        two_player_mode = 1'b0;
        score_p1 = 8'd6; score_p2 = 8'd6;
        cyc(2);
        end_game_early = 1'b1;
        cyc(1);
        check_val("t2b_score", screen_id, 4);
        check_val("t2b_winner_tie", winner, 0);
        check_val("t2b_final_p1", final_p1, 6);
        end_game_early = 1'b0;
        play_again = 1'b1;
        cyc(20);
        check_val("t2b_replay", screen_id, 5);
        play_again = 1'b0;
        cyc(1);
        check_val("t2b_mode", screen_id, 1);

        // Tests 4/5: snitch timing and time-turner bonus within one PLAY1 round
        snitch_powerup = 1'b1;
        cyc(2);
        check_val("t4_mode_edge_ignored", snitch_active, 0);
        selected_a_mode = 1'b1;
        cyc(1);
        check_val("t4_play1", screen_id, 2);
        check_val("t4_high_on_entry", snitch_active, 0);
        e = 0;
        selected_a_mode = 1'b0; snitch_powerup = 1'b0;
        score_p1 = 8'd1; score_p2 = 8'd9;
        run_to(2);
        snitch_powerup = 1'b1;
        run_to(3);
        check_val("t4_snitch_on", snitch_active, 1);
        snitch_powerup = 1'b0;
        run_to(10);
        check_val("t5_secs_4", secs_left, 4);
        run_to(11);
        time_turner_on = 1'b1;
        run_to(12);
        check_val("t5_tt_clamped", secs_left, 5);
        time_turner_on = 1'b0;
        run_to(19);
        check_val("t4_snitch_tick1", snitch_active, 1);
        run_to(20);
        check_val("t4_snitch_off", snitch_active, 0);
        check_val("t5_secs_after", secs_left, 4);
        snitch_powerup = 1'b1;
        run_to(21);
        check_val("t4_snitch_on2", snitch_active, 1);
        snitch_powerup = 1'b0;
        run_to(30);
        snitch_powerup = 1'b1;
        run_to(31);
        check_val("t4_reload", snitch_active, 1);
        snitch_powerup = 1'b0;
        run_to(49);
        check_val("t4_extended", snitch_active, 1);
        run_to(50);
        check_val("t4_extended_off", snitch_active, 0);
        check_val("t5_secs_1", secs_left, 1);
        run_to(59);
        time_turner_on = 1'b1;
        run_to(60);
        check_val("t5_tick_and_tt", secs_left, 3);
        check_val("t5_continues", screen_id, 2);
        time_turner_on = 1'b0;
        run_to(84);
        snitch_powerup = 1'b1;
        run_to(85);
        check_val("t4_snitch_late", snitch_active, 1);
        snitch_powerup = 1'b0;
        run_to(89);
        check_val("t5_secs_89", secs_left, 1);
        run_to(90);
        check_val("t5_score", screen_id, 4);
        check_val("t4_snitch_forced_off", snitch_active, 0);
        check_val("t5_winner", winner, 1);
        play_again = 1'b1;
        cyc(19);
        check_val("t4_hold", screen_id, 4);
        cyc(1);
        check_val("t4_replay", screen_id, 5);
        play_again = 1'b0;
        cyc(1);
        check_val("t4_mode", screen_id, 1);

        // Test 6: asynchronous reset in the middle of a two-player round
        two_player_mode = 1'b1;
        cyc(1);
        check_val("t6_play2", screen_id, 3);
        two_player_mode = 1'b0;
        cyc(1);
        snitch_powerup = 1'b1;
        cyc(1);
        check_val("t6_snitch_on", snitch_active, 1);
        snitch_powerup = 1'b0;
        logo = 1'b1;
        cyc(3);
        #3 reset = 1'b1;
        #1;
        check_val("t6_async_screen", screen_id, 0);
        check_val("t6_async_secs", secs_left, 0);
        check_val("t6_async_snitch", snitch_active, 0);
        check_val("t6_async_final_p1", final_p1, 0);
        check_val("t6_async_final_p2", final_p2, 0);
        check_val("t6_async_winner", winner, 0);
        check_val("t6_async_restart", restart, 0);
        cyc(2);
        reset = 1'b0;
        cyc(3);
        check_val("t6_logo_after", screen_id, 0);
        check_val("restart_pulses", restart_cnt, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
